sc_game_fsm: RTL and testbench



---
 rtl/sc_game_fsm_if.sv | 22 ++
 rtl/sc_game_fsm.sv | 107 ++++++++++
 tb/tb_sc_game_fsm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sc_game_fsm_if.sv
// rtl/sc_game_fsm_if.sv - game-FSM signal bundle between the frog-game datapath and sc_game_fsm
interface sc_game_fsm_if #(
  parameter int DATAWIDTH_ESTADO = 3
);
  logic                        SC_FSM_START_IN;
  logic                        SC_FSM_LLEGO_IN;
  logic                        SC_FSM_PERDIO_IN;
  logic                        SC_FSM_GANO_IN;
  logic [DATAWIDTH_ESTADO-1:0] SC_FSM_ESTADO_OUT;
  logic                        SC_FSM_RANAINI_OUT;
  logic [1:0]                  SC_FSM_VIDAS_OUT;

  modport master (
    output SC_FSM_START_IN, SC_FSM_LLEGO_IN, SC_FSM_PERDIO_IN, SC_FSM_GANO_IN,
    input  SC_FSM_ESTADO_OUT, SC_FSM_RANAINI_OUT, SC_FSM_VIDAS_OUT
  );

  modport slave (
    input  SC_FSM_START_IN, SC_FSM_LLEGO_IN, SC_FSM_PERDIO_IN, SC_FSM_GANO_IN,
    output SC_FSM_ESTADO_OUT, SC_FSM_RANAINI_OUT, SC_FSM_VIDAS_OUT
  );
endinterface

// File: rtl/sc_game_fsm.sv
// rtl/sc_game_fsm.sv - frog game-level FSM: start, lives, hit recovery, win/lose, frog-delivered pulse
module sc_game_fsm #(
  parameter int DATAWIDTH_ESTADO = 3,
  parameter int LIVES_INIT       = 3,
  parameter int HIT_HOLD         = 50_000_000,
  parameter int ARRIVE_GAP       = 1_000_000
) (
  input  logic          SC_CSCOUNT_CLOCK_50,
  input  logic          SC_CSCOUNT_RESET,
  sc_game_fsm_if.slave  bus
);

  localparam int TW = $clog2(HIT_HOLD + 1);
  localparam int GW = $clog2(ARRIVE_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_PLAY = 3'b111,
    S_HIT  = 3'b101,
    S_WIN  = 3'b010,
    S_LOSE = 3'b011
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    vidas_q, vidas_d;
  logic          ranaini_q, ranaini_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          start_s1_q, start_s2_q, start_s3_q;
  logic          llego_q;
  logic          start_pe, llego_pe;

  always_comb begin
    start_pe  = start_s2_q & ~start_s3_q;
    llego_pe  = bus.SC_FSM_LLEGO_IN & ~llego_q;
    state_d   = state_q;
    vidas_d   = vidas_q;
    timer_d   = timer_q;
    ranaini_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_pe) begin
          state_d = S_PLAY;
          vidas_d = 2'(LIVES_INIT);
        end
      end
      S_PLAY: begin
        // Win beats collision, collision beats a delivered frog.
        if (bus.SC_FSM_GANO_IN) begin
          state_d = S_WIN;
        end else if (bus.SC_FSM_PERDIO_IN) begin
          if (vidas_q != 2'd0) vidas_d = vidas_q - 2'd1;
          if (vidas_q <= 2'd1) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_HIT;
            timer_d = TW'(HIT_HOLD - 1);
          end
        end else if (llego_pe && gap_q == '0) begin
          ranaini_d = 1'b1;
        end
      end
      S_HIT: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        else if (!bus.SC_FSM_PERDIO_IN) state_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (start_pe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ranaini_d)              gap_d = GW'(ARRIVE_GAP - 1);
    else if (state_d != S_PLAY) gap_d = '0;
    else if (gap_q != '0)       gap_d = gap_q - 1'b1;
    else                        gap_d = gap_q;
  end

  always_ff @(posedge SC_CSCOUNT_CLOCK_50 or posedge SC_CSCOUNT_RESET) begin
    if (SC_CSCOUNT_RESET) begin
      state_q    <= S_IDLE;
      vidas_q    <= 2'd0;
      ranaini_q  <= 1'b0;
      timer_q    <= '0;
      gap_q      <= '0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      llego_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vidas_q    <= vidas_d;
      ranaini_q  <= ranaini_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      start_s1_q <= bus.SC_FSM_START_IN;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      llego_q    <= bus.SC_FSM_LLEGO_IN;
    end
  end

  assign bus.SC_FSM_ESTADO_OUT  = DATAWIDTH_ESTADO'(state_q);
  assign bus.SC_FSM_RANAINI_OUT = ranaini_q;
  assign bus.SC_FSM_VIDAS_OUT   = vidas_q;

endmodule

// File: tb/tb_sc_game_fsm.sv
// tb/tb_sc_game_fsm.sv - scoreboard testbench for sc_game_fsm
module tb_sc_game_fsm;

  localparam int LIVES = 3;
  localparam int HOLD  = 5;
  localparam int GAP   = 8;

  localparam logic [2:0] E_IDLE = 3'b000;
  localparam logic [2:0] E_PLAY = 3'b111;
  localparam logic [2:0] E_HIT  = 3'b101;
  localparam logic [2:0] E_WIN  = 3'b010;
  localparam logic [2:0] E_LOSE = 3'b011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sc_game_fsm_if #(.DATAWIDTH_ESTADO(3)) bus ();

  sc_game_fsm #(
    .DATAWIDTH_ESTADO(3),
    .LIVES_INIT(LIVES),
    .HIT_HOLD(HOLD),
    .ARRIVE_GAP(GAP)
  ) dut (
    .SC_CSCOUNT_CLOCK_50(clk),
    .SC_CSCOUNT_RESET(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [2:0] e;
    logic       r;
    logic [1:0] v;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [2:0] m_state;
  logic [1:0] m_vidas;
  int         m_timer;
  int         m_gap;
  logic [2:0] m_sync;
  logic       m_llego;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = E_IDLE;
    m_vidas = 2'd0;
    m_timer = 0;
    m_gap   = 0;
    m_sync  = 3'b000;
    m_llego = 1'b0;
  endtask

  // One clock: drive inputs, push the modelled result, then compare after the edge.
  task automatic cycle(input logic st, input logic ll, input logic pe, input logic ga);
    logic       spe, lpe, nr;
    logic [2:0] ns;
    logic [1:0] nv;
    int         nt, ng;
    exp_t       o;
    bus.SC_FSM_START_IN  = st;
    bus.SC_FSM_LLEGO_IN  = ll;
    bus.SC_FSM_PERDIO_IN = pe;
    bus.SC_FSM_GANO_IN   = ga;
    spe = m_sync[1] & ~m_sync[2];
    lpe = ll & ~m_llego;
    ns = m_state; nv = m_vidas; nr = 1'b0; nt = m_timer;
    case (m_state)
      E_IDLE: if (spe) begin ns = E_PLAY; nv = 2'(LIVES); end
      E_PLAY: begin
        if (ga) ns = E_WIN;
        else if (pe) begin
          nv = (m_vidas > 0) ? m_vidas - 2'd1 : 2'd0;
          if (nv == 0) ns = E_LOSE;
          else begin ns = E_HIT; nt = HOLD - 1; end
        end else if (lpe && m_gap == 0) nr = 1'b1;
      end
      E_HIT: begin
        if (m_timer > 0) nt = m_timer - 1;
        else if (!pe) ns = E_PLAY;
      end
      E_WIN, E_LOSE: if (spe) ns = E_IDLE;
      default: ns = E_IDLE;
    endcase
    ng = nr ? GAP - 1 : (ns != E_PLAY) ? 0 : (m_gap > 0 ? m_gap - 1 : 0);
    m_sync  = {m_sync[1:0], st};
    m_llego = ll;
    m_state = ns; m_vidas = nv; m_timer = nt; m_gap = ng;
    sb.push_back('{ns, nr, nv});
    @(posedge clk);
    #2;
    o = sb.pop_front();
    chk("estado", 32'(bus.SC_FSM_ESTADO_OUT), 32'(o.e));
    chk("ranaini", 32'(bus.SC_FSM_RANAINI_OUT), 32'(o.r));
    chk("vidas", 32'(bus.SC_FSM_VIDAS_OUT), 32'(o.v));
  endtask

  task automatic start_press();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses, hits;
    bus.SC_FSM_START_IN  = 1'b0;
    bus.SC_FSM_LLEGO_IN  = 1'b0;
    bus.SC_FSM_PERDIO_IN = 1'b0;
    bus.SC_FSM_GANO_IN   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_estado", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_IDLE));
    chk("rst_ranaini", 32'(bus.SC_FSM_RANAINI_OUT), 0);
    chk("rst_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start latency: third edge after the pin rises enters PLAY
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_not_yet", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_IDLE));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_play", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));
    chk("t1_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Arrival gap: edges at 0, 4 and 10 cycles give two pulses
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, (i == 0 || i == 4 || i == 10), 1'b0, 1'b0);
      if (bus.SC_FSM_RANAINI_OUT) begin
        pulses++;
        chk("t2_pulse_in_play", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));
      end
    end
    chk("t2_pulses", pulses, 2);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Short collision
    hits = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    if (bus.SC_FSM_ESTADO_OUT == E_HIT) hits++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.SC_FSM_ESTADO_OUT == E_HIT) hits++;
    end
    chk("t3_hit_len", hits, 5);
    chk("t3_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 2);
    chk("t3_back_play", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));

    // Collision held past the hit timer: one life only
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (bus.SC_FSM_ESTADO_OUT == E_HIT) hits++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_held_hit_len", hits, 8);
    chk("t3_held_exit", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));
    chk("t3_held_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 1);

    // Last life lost
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_lose", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_LOSE));
    chk("t4_vidas0", 32'(bus.SC_FSM_VIDAS_OUT), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    start_press();
    chk("t4_idle", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_IDLE));
    start_press();
    chk("t4_replay", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));
    chk("t4_vidas3", 32'(bus.SC_FSM_VIDAS_OUT), 3);

    // Win, collision and arrival all in one cycle
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_win", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_WIN));
    chk("t5_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 3);
    chk("t5_no_pulse", 32'(bus.SC_FSM_RANAINI_OUT), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    start_press();
    start_press();
    chk("t5_replay", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));

    // Asynchronous reset mid-HIT
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_in_hit", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_HIT));
    #1 rst = 1'b1;
    #1;
    chk("t6_async_estado", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_IDLE));
    chk("t6_async_ranaini", 32'(bus.SC_FSM_RANAINI_OUT), 0);
    chk("t6_async_vidas", 32'(bus.SC_FSM_VIDAS_OUT), 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_idles", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_IDLE));
    start_press();
    chk("t6_restart", 32'(bus.SC_FSM_ESTADO_OUT), 32'(E_PLAY));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
